// File: rtl/clint_timer_if.sv
// rtl/clint_timer_if.sv - word-wide load/store port between a bus master and clint_timer
//
// Signals:
//   req    master -> slave  one access per asserted cycle
//   we     master -> slave  1 = write, 0 = read
//   addr   master -> slave  byte address, addr[4:2] selects the register
//   wdata  master -> slave  write data
//   rdata  slave -> master  read data, valid while ack = 1, otherwise 0
//   ack    slave -> master  one-cycle completion pulse, one cycle after req

interface clint_timer_if;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - core-local interruptor: mtime/mtimecmp/msip plus external irq sync
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   bus            clint_timer_if.slave load/store port (req/we/addr/wdata/rdata/ack)
//   ext_irq_async  asynchronous external interrupt level
//   mtip           machine timer interrupt pending (registered mtime >= mtimecmp)
//   msip           machine software interrupt pending
//   meip           machine external interrupt pending (two-flop synchronised)
//
// Register map (addr[4:2]): 0 msip, 1 mtimecmp lo, 2 mtimecmp hi, 3 mtime lo,
// 4 mtime hi, 5..7 unmapped (read 0, writes ignored, still acked).
//
// Optional build macro CLINT_HI_LATCH_EN: a read of mtime lo snapshots mtime hi
// into a shadow register, and reads of mtime hi return that shadow.

module clint_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    clint_timer_if.slave bus,
    input  logic         ext_irq_async,
    output logic         mtip,
    output logic         msip,
    output logic         meip
);
    localparam logic [15:0] PS_LAST  = 16'(PRESCALE - 1);
    localparam logic [2:0]  A_MSIP   = 3'd0;
    localparam logic [2:0]  A_CMP_LO = 3'd1;
    localparam logic [2:0]  A_CMP_HI = 3'd2;
    localparam logic [2:0]  A_MT_LO  = 3'd3;
    localparam logic [2:0]  A_MT_HI  = 3'd4;

    logic [63:0] mtime;
    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp;
    logic [15:0] pcnt;
    logic [2:0]  sel;
    logic        wr;
    logic        rd;
    logic        tick;
    logic        mtime_wr;
    logic [31:0] rd_mux;
    logic [31:0] mtime_hi_rd;
    logic        ext_sync1;
    logic        unused_addr_lsbs;

    assign sel      = bus.addr[4:2];
    assign wr       = bus.req & bus.we;
    assign rd       = bus.req & ~bus.we;
    assign tick     = (pcnt == PS_LAST);
    assign mtime_wr = wr && ((sel == A_MT_LO) || (sel == A_MT_HI));

    // Byte lanes are not decoded; the low address bits are deliberately dropped.
    assign unused_addr_lsbs = ^bus.addr[1:0];

    // A bus write to either mtime half replaces the increment for that edge;
    // the untouched half keeps its pre-edge value.
    always_comb begin
        mtime_nxt = tick ? (mtime + 64'd1) : mtime;
        if (wr && (sel == A_MT_LO)) begin
            mtime_nxt = {mtime[63:32], bus.wdata};
        end else if (wr && (sel == A_MT_HI)) begin
            mtime_nxt = {bus.wdata, mtime[31:0]};
        end
    end

`ifdef CLINT_HI_LATCH_EN
    logic [31:0] mtime_hi_shadow;

    // Snapshot taken at the lo read so a lo-then-hi read pair is coherent even
    // if a carry ripples into the hi word between the two accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_hi_shadow <= 32'd0;
        end else if (rd && (sel == A_MT_LO)) begin
            mtime_hi_shadow <= mtime[63:32];
        end else if (mtime_wr) begin
            mtime_hi_shadow <= mtime_nxt[63:32];
        end
    end

    assign mtime_hi_rd = mtime_hi_shadow;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (sel)
            A_MSIP:   rd_mux = {31'd0, msip};
            A_CMP_LO: rd_mux = mtimecmp[31:0];
            A_CMP_HI: rd_mux = mtimecmp[63:32];
            A_MT_LO:  rd_mux = mtime[31:0];
            A_MT_HI:  rd_mux = mtime_hi_rd;
            default:  rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip      <= 1'b0;
            pcnt      <= 16'd0;
            mtip      <= 1'b0;
            ext_sync1 <= 1'b0;
            meip      <= 1'b0;
            bus.ack   <= 1'b0;
            bus.rdata <= 32'd0;
        end else begin
            mtime <= mtime_nxt;

            // Writing mtime restarts the prescale period from the write edge.
            if (mtime_wr || tick) begin
                pcnt <= 16'd0;
            end else begin
                pcnt <= pcnt + 16'd1;
            end

            if (wr && (sel == A_CMP_LO)) begin
                mtimecmp[31:0] <= bus.wdata;
            end
            if (wr && (sel == A_CMP_HI)) begin
                mtimecmp[63:32] <= bus.wdata;
            end
            if (wr && (sel == A_MSIP)) begin
                msip <= bus.wdata[0];
            end

            // Compare uses pre-edge values, so mtip lags mtime by one cycle.
            mtip <= (mtime >= mtimecmp);

            ext_sync1 <= ext_irq_async;
            meip      <= ext_sync1;

            bus.ack   <= bus.req;
            bus.rdata <= rd ? rd_mux : 32'd0;
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - scoreboard bench for clint_timer (PRESCALE 1 and 4 instances)

module tb_clint_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_d = 1'b0;
    logic        we_d = 1'b0;
    logic [4:0]  addr_d = 5'd0;
    logic [31:0] wdata_d = 32'd0;
    int          sel_d = 0;
    logic        ext_d = 1'b0;

    always #5 clk = ~clk;

`ifdef CLINT_HI_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    clint_timer_if bus0 ();
    clint_timer_if bus1 ();

    assign bus0.req   = req_d && (sel_d == 0);
    assign bus0.we    = we_d;
    assign bus0.addr  = addr_d;
    assign bus0.wdata = wdata_d;
    assign bus1.req   = req_d && (sel_d == 1);
    assign bus1.we    = we_d;
    assign bus1.addr  = addr_d;
    assign bus1.wdata = wdata_d;

    logic mtip0, msip0, meip0, mtip1, msip1, meip1;
    logic [1:0]  mtip_v, msip_v, meip_v, ack_v;
    logic [31:0] rdata_v [2];

    assign mtip_v     = {mtip1, mtip0};
    assign msip_v     = {msip1, msip0};
    assign meip_v     = {meip1, meip0};
    assign ack_v      = {bus1.ack, bus0.ack};
    assign rdata_v[0] = bus0.rdata;
    assign rdata_v[1] = bus1.rdata;

    clint_timer #(.PRESCALE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .ext_irq_async(ext_d),
        .mtip(mtip0), .msip(msip0), .meip(meip0)
    );

    clint_timer #(.PRESCALE(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .ext_irq_async(ext_d),
        .mtip(mtip1), .msip(msip1), .meip(meip1)
    );

    // Model state: mtime is base + floor((edge - kb) / prescale), i.e. a
    // closed-form function of the edge count since the last mtime write.
    typedef struct packed {
        logic [63:0] base;
        int          kb;
        logic [63:0] cmp;
        logic        msip;
        logic [31:0] shadow;
    } snap_t;

    typedef struct packed {
        int          cyc;
        logic [31:0] data;
        logic        rd;
    } exp_t;

    snap_t cur [2];
    snap_t old [2];
    int    wedge [2];
    exp_t  q0 [$];
    exp_t  q1 [$];
    int    cyc;
    int    errors = 0;
    int    checks = 0;
    logic  ext_prev = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ps(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    // State after edge e; only the latest write edge can still be ahead.
    function automatic snap_t st(input int d, input int e);
        return (e >= wedge[d]) ? cur[d] : old[d];
    endfunction

    function automatic logic [63:0] mt(input int d, input snap_t s, input int e);
        return s.base + 64'((e - s.kb) / ps(d));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cur[d].base   = 64'd0;
            cur[d].kb     = 0;
            cur[d].cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
            cur[d].msip   = 1'b0;
            cur[d].shadow = 32'd0;
            old[d]        = cur[d];
            wedge[d]      = 0;
        end
    endtask

    // Issue one access at a negedge; it is sampled at the next edge (cyc + 1).
    task automatic access(input int d, input bit w, input logic [4:0] a, input logic [31:0] wd);
        int          c;
        snap_t       s;
        logic [63:0] m;
        logic [31:0] rv;
        exp_t        e;
        c  = cyc;
        s  = cur[d];
        m  = mt(d, s, c);
        rv = 32'd0;
        case (a[4:2])
            3'd0: rv = {31'd0, s.msip};
            3'd1: rv = s.cmp[31:0];
            3'd2: rv = s.cmp[63:32];
            3'd3: rv = m[31:0];
            3'd4: rv = LATCH ? s.shadow : m[63:32];
            default: rv = 32'd0;
        endcase
        if (w) begin
            case (a[4:2])
                3'd0: s.msip = wd[0];
                3'd1: s.cmp[31:0] = wd;
                3'd2: s.cmp[63:32] = wd;
                3'd3: begin s.base = {m[63:32], wd}; s.kb = c + 1; s.shadow = m[63:32]; end
                3'd4: begin s.base = {wd, m[31:0]}; s.kb = c + 1; s.shadow = wd; end
                default: ;
            endcase
        end else if (a[4:2] == 3'd3) begin
            s.shadow = m[63:32];
        end
        old[d]   = cur[d];
        cur[d]   = s;
        wedge[d] = c + 1;
        e.cyc  = c + 1;
        e.data = rv;
        e.rd   = !w;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        sel_d   = d;
        we_d    = w;
        addr_d  = a;
        wdata_d = wd;
        req_d   = 1'b1;
        @(negedge clk);
        req_d   = 1'b0;
    endtask

    // Monitor: interrupt outputs every cycle, bus responses against the queue.
    initial begin
        snap_t sp;
        exp_t  e;
        bit    have;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && cyc >= 1) begin
                for (int d = 0; d < 2; d++) begin
                    sp = st(d, cyc - 1);
                    chk($sformatf("mtip%0d", d), mtip_v[d], (mt(d, sp, cyc - 1) >= sp.cmp));
                    chk($sformatf("msip%0d", d), msip_v[d], st(d, cyc).msip);
                    chk($sformatf("meip%0d", d), meip_v[d], ext_prev);
                    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (have) e = (d == 0) ? q0[0] : q1[0];
                    if (ack_v[d]) begin
                        if (!have) begin
                            chk($sformatf("ack_spurious%0d", d), 1, 0);
                        end else begin
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                            chk($sformatf("ack_cycle%0d", d), cyc, e.cyc);
                            if (e.rd) chk($sformatf("rdata%0d", d), rdata_v[d], e.data);
                        end
                    end else begin
                        chk($sformatf("rdata_idle%0d", d), rdata_v[d], 0);
                        if (have && e.cyc <= cyc) begin
                            chk($sformatf("ack_missing%0d", d), 0, 1);
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                end
                ext_prev = ext_d;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Free-running mtime after reset.
        repeat (10) @(negedge clk);
        access(0, 0, 5'h0C, 0);
        access(0, 0, 5'h00, 0);

        // mtip rise at mtime == 20, then fall after raising mtimecmp.
        access(0, 1, 5'h08, 32'd0);
        access(0, 1, 5'h10, 32'd0);
        access(0, 1, 5'h0C, 32'd0);
        access(0, 1, 5'h04, 32'd20);
        repeat (30) @(negedge clk);
        access(0, 1, 5'h04, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);

        // Carry from lo into hi.
        access(0, 1, 5'h10, 32'd0);
        access(0, 1, 5'h0C, 32'hFFFF_FFFE);
        @(negedge clk);
        access(0, 0, 5'h0C, 0);
        access(0, 0, 5'h10, 0);

        // Prescale 4 with a mid-count mtime write restarting the period.
        repeat (5) @(negedge clk);
        access(1, 1, 5'h0C, 32'd100);
        repeat (10) access(1, 0, 5'h0C, 0);

        // Back-to-back accesses.
        access(0, 1, 5'h00, 32'd1);
        access(0, 0, 5'h00, 0);
        access(0, 0, 5'h1C, 0);

        // External interrupt pulse.
        ext_d = 1'b1;
        repeat (5) @(negedge clk);
        ext_d = 1'b0;
        repeat (4) @(negedge clk);

        // lo-then-hi read across a carry.
        access(1, 1, 5'h10, 32'd0);
        access(1, 1, 5'h0C, 32'hFFFF_FFFF);
        access(1, 0, 5'h0C, 0);
        repeat (6) @(negedge clk);
        access(1, 0, 5'h10, 0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) ext_d = ~ext_d;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            else access($urandom_range(0, 1), 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
        end
        ext_d = 1'b0;
        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        // Reset while ack is high and another access is pending.
        access(0, 1, 5'h00, 32'd1);
        access(0, 0, 5'h0C, 0);
        sel_d  = 0;
        we_d   = 1'b0;
        addr_d = 5'h00;
        req_d  = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("rst_ack", ack_v[0], 0);
        chk("rst_rdata", rdata_v[0], 0);
        chk("rst_msip", msip_v[0], 0);
        chk("rst_mtip", mtip_v[0], 0);
        chk("rst_meip", meip_v[0], 0);
        @(posedge clk);
        #1;
        chk("rst_ack_dropped", ack_v[0], 0);
        chk("rst_rdata_dropped", rdata_v[0], 0);
        req_d = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor that sits directly upstream of the machine interrupt-pending CSR.
- Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and the msip bit, all reachable over a simple word-wide load/store port.
- Synchronises the asynchronous external interrupt line.
- Drives mtip, msip and meip into the CSR unit's interrupt-pending inputs.

Parameters:
- PRESCALE, 1, number of clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  bus access request, one access per asserted cycle
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  5  byte address; only addr[4:2] decoded, addr[1:0] ignored
- wdata  input  32  write data, sampled with req
- rdata  output  32  read data, valid while ack = 1
- ack  output  1  one-cycle completion pulse
- ext_irq_async  input  1  asynchronous external interrupt level
- mtip  output  1  machine timer interrupt pending
- msip  output  1  machine software interrupt pending
- meip  output  1  machine external interrupt pending (synchronised)

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. All state is updated on the rising edge of clk.
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0.
  - prescaler count = 0; synchroniser flops = 0.
  - mtip = 0; meip = 0; ack = 0; rdata = 0.
- Register map, by addr[4:2]:
  - 0 = msip (bit0 read/write, bits 31:1 read 0, writes ignored)
  - 1 = mtimecmp[31:0]
  - 2 = mtimecmp[63:32]
  - 3 = mtime[31:0]
  - 4 = mtime[63:32]
  - 5..7 = unmapped: read 0, writes ignored, still acked.
- Bus handshake:
  - A req at cycle n gives ack = 1 at cycle n+1, with rdata registered.
  - Back-to-back req every cycle is legal; ack follows each one by one cycle.
  - rdata = 0 whenever ack = 0.
  - A write takes effect at the same edge that raises ack.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - mtime increments by 1 on the edge where the count equals PRESCALE-1; the count then wraps to 0.
  - PRESCALE = 1 gives an increment every cycle.
- Wrap: mtime 64'hFFFF_FFFF_FFFF_FFFF increments to 0 with no flag.
- Write to mtime_lo or mtime_hi:
  - The written half takes wdata; the other half keeps its current value (no increment applied that edge).
  - The prescaler count is cleared to 0.
  - A bus write always wins over a simultaneous increment.
- Low-to-high carry: the increment is a full 64-bit add; a carry out of bit 31 updates mtime_hi on the same edge.
- mtip:
  - Registered: mtip(n+1) = (mtime(n) >= mtimecmp(n)), unsigned 64-bit compare.
  - Level-sensitive; it stays high until software raises mtimecmp or lowers mtime.
- msip: direct register output of the msip bit.
- meip: two-flop synchroniser on ext_irq_async, so meip follows the input 2 cycles later; no edge detection.
- Reset mid-access: ack, rdata and all state return to their reset values immediately; the pending access is dropped.

Optional Feature:
- Macro: CLINT_HI_LATCH_EN.
- Defined:
  - A read of mtime_lo also captures mtime[63:32] into a 32-bit shadow register on the same edge.
  - A subsequent read of mtime_hi returns the shadow, giving a coherent 64-bit snapshot across the lo-then-hi read pair.
  - The shadow resets to 0 and is also loaded by any write to mtime_lo or mtime_hi, with the resulting mtime[63:32].
- Not defined: a read of mtime_hi returns the live mtime[63:32]; no shadow register exists.

Test Plan:
- Reset release with PRESCALE = 1, no bus traffic, 10 cycles -> read mtime_lo returns 10 (±access latency, checked against a model); mtip = 0, msip = 0, meip = 0.
- Write mtimecmp_hi = 0, then mtimecmp_lo = 20, with mtime starting at 0 -> mtip rises exactly one cycle after mtime reaches 20; then write mtimecmp_lo = 0xFFFF_FFFF -> mtip falls the cycle after.
- Write mtime_hi = 0, then mtime_lo = 0xFFFF_FFFE, with PRESCALE = 1 -> two cycles later mtime = 0x1_0000_0000 (carry into the hi word verified).
- PRESCALE = 4 -> mtime increments once every 4 cycles; writing mtime_lo = 100 mid-count restarts the prescaler, so the next increment to 101 comes 4 cycles after the write edge.
- Back-to-back req on 3 consecutive cycles (write msip = 1; read addr 0x00; read addr 0x1C) -> three consecutive ack pulses; rdata = 1 then 0; msip = 1 from the cycle after the write.
- Pulse ext_irq_async high for 5 cycles -> meip is high for 5 cycles starting 2 cycles later. With CLINT_HI_LATCH_EN defined and mtime = 0x0000_0000_FFFF_FFFF: read lo, then read hi after the carry -> hi read returns 0.
